// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array data path: data width,
// saturation limits and the output collector state encoding.
package sa_pkg;

  localparam int DATA_W = 16;

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    REARM   = 2'd3
  } state_t;

endpackage

// File: rtl/sa_deskew.sv
// Per-lane delay line: delays a lane's data and valid by DELAY cycles so
// staircase-skewed lanes line up. DELAY=0 is a plain pass-through.
module sa_deskew #(
  parameter int DATA_W = 16,
  parameter int DELAY  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data
);

  generate
    if (DELAY == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, flush};
      assign out_valid   = in_valid;
      assign out_data    = in_data;
    end else begin : g_delay
      logic [DELAY-1:0]         valid_q, valid_d;
      logic signed [DATA_W-1:0] data_q [DELAY];
      logic signed [DATA_W-1:0] data_d [DELAY];

      always_comb begin
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        for (int i = 1; i < DELAY; i++) begin
          valid_d[i] = valid_q[i-1];
          data_d[i]  = data_q[i-1];
        end
        // A flush drops everything in flight, e.g. when a frame is aborted.
        if (flush) begin
          valid_d = '0;
          for (int i = 0; i < DELAY; i++) data_d[i] = '0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= '0;
          for (int i = 0; i < DELAY; i++) data_q[i] <= '0;
        end else begin
          valid_q <= valid_d;
          for (int i = 0; i < DELAY; i++) data_q[i] <= data_d[i];
        end
      end

      assign out_valid = valid_q[DELAY-1];
      assign out_data  = data_q[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/sa_output_collector.sv
// Receiving end of the SA path: de-skews the three lanes, sums them with
// saturation, buffers the OUT x OUT map and drains it over valid/ready.
module sa_output_collector #(
  parameter int SIZE   = 7,
  parameter int K      = 3,
  parameter int DATA_W = sa_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     srt_sig,
  input  logic signed [DATA_W-1:0] in1,
  input  logic signed [DATA_W-1:0] in2,
  input  logic signed [DATA_W-1:0] in3,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     busy,
  output logic                     done
);
  import sa_pkg::*;

  localparam int OUT    = SIZE - K + 1;
  localparam int N_SAMP = OUT * SIZE;
  localparam int N_OUT  = OUT * OUT;
  localparam int IN_W   = $clog2(N_SAMP + 1);
  localparam int COL_W  = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int ROW_W  = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int SUM_W  = DATA_W + 2;

  localparam logic [IN_W-1:0]  IN_END    = IN_W'(N_SAMP);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(OUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_OUT - 1);

  localparam logic signed [SUM_W-1:0] SUM_HI = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_LO = {3'b111, {(DATA_W-1){1'b0}}};

  state_t                   state_q, state_d;
  logic                     srt_q;
  logic [IN_W-1:0]          in_cnt_q, in_cnt_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [IDX_W-1:0]         wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]         rd_idx_q, rd_idx_d;
  logic signed [DATA_W-1:0] sum_q, sum_d;
  logic                     sum_valid_q, sum_valid_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;

  logic signed [DATA_W-1:0] result_mem [N_OUT];

  logic                     start, lane1_valid, abort, store, last_sample;
  logic                     a_valid, unused_valid2, unused_valid3;
  logic signed [DATA_W-1:0] a1, a2, a3;
  logic signed [SUM_W-1:0]  sum_ext;
  logic [IDX_W-1:0]         rd_next;

  assign start = srt_sig && !srt_q;
  assign lane1_valid = (state_q == IDLE && start) ||
                       (state_q == CAPTURE && srt_sig && in_cnt_q < IN_END);
  assign abort = (state_q == CAPTURE) && !srt_sig && (in_cnt_q < IN_END);

  sa_deskew #(.DATA_W(DATA_W), .DELAY(K - 1)) u_lane1 (
    .clk(clk), .rst(rst), .flush(abort), .in_valid(lane1_valid),
    .in_data(in1), .out_valid(a_valid), .out_data(a1)
  );
  sa_deskew #(.DATA_W(DATA_W), .DELAY(K - 2)) u_lane2 (
    .clk(clk), .rst(rst), .flush(abort), .in_valid(lane1_valid),
    .in_data(in2), .out_valid(unused_valid2), .out_data(a2)
  );
  sa_deskew #(.DATA_W(DATA_W), .DELAY(K - 3)) u_lane3 (
    .clk(clk), .rst(rst), .flush(abort), .in_valid(lane1_valid),
    .in_data(in3), .out_valid(unused_valid3), .out_data(a3)
  );

  assign sum_ext = {{2{a1[DATA_W-1]}}, a1} + {{2{a2[DATA_W-1]}}, a2} +
                   {{2{a3[DATA_W-1]}}, a3};

  // The first K-1 columns of each row window are warm-up and never stored.
  assign store       = sum_valid_q && (state_q == CAPTURE) && (col_q >= COL_FIRST);
  assign last_sample = sum_valid_q && (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign rd_next     = rd_idx_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sum_valid_d = a_valid && (state_q == CAPTURE) && !abort;
    if (sum_ext > SUM_HI)      sum_d = SUM_HI[DATA_W-1:0];
    else if (sum_ext < SUM_LO) sum_d = SUM_LO[DATA_W-1:0];
    else                       sum_d = sum_ext[DATA_W-1:0];

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CAPTURE;
          in_cnt_d = IN_W'(1);
          col_d    = '0;
          row_d    = '0;
          wr_idx_d = '0;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_d  = IDLE;
          in_cnt_d = '0;
          col_d    = '0;
          row_d    = '0;
          wr_idx_d = '0;
        end else begin
          if (lane1_valid) in_cnt_d = in_cnt_q + IN_W'(1);
          if (store) wr_idx_d = wr_idx_q + IDX_W'(1);
          if (sum_valid_q) begin
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
          if (last_sample) begin
            state_d     = DRAIN;
            in_cnt_d    = '0;
            col_d       = '0;
            row_d       = '0;
            wr_idx_d    = '0;
            rd_idx_d    = '0;
            out_valid_d = 1'b1;
            out_data_d  = result_mem[0];
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (rd_idx_q == IDX_LAST) begin
            state_d     = REARM;
            out_valid_d = 1'b0;
            rd_idx_d    = '0;
          end else begin
            rd_idx_d   = rd_next;
            out_data_d = result_mem[rd_next];
          end
        end
      end
      REARM: begin
        if (!srt_sig) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      srt_q       <= 1'b0;
      in_cnt_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      srt_q       <= srt_sig;
      in_cnt_q    <= in_cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Result storage needs no reset; it is fully rewritten before every drain.
  always_ff @(posedge clk) begin
    if (store) result_mem[wr_idx_q] <= sum_q;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == CAPTURE) || (state_q == DRAIN);
  assign done      = (state_q == DRAIN) && out_valid_q && out_ready && (rd_idx_q == IDX_LAST);

endmodule

// File: tb/tb_sa_output_collector.sv
// Scoreboard bench for sa_output_collector: directed frames push expected
// beats into a queue, and a monitor pops and compares on every accepted beat.
module tb_sa_output_collector;
  import sa_pkg::*;

  localparam int SIZE = 7;
  localparam int K    = 3;
  localparam int OUT  = 5;
  localparam int NS   = 35;
  localparam int NO   = 25;

  logic clk = 1'b0;
  logic rst, srt_sig, out_ready, out_valid, busy, done;
  logic signed [15:0] in1, in2, in3, out_data;

  int checks   = 0;
  int failures = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  bit bp_en    = 1'b0;
  bit prev_stall = 1'b0;
  logic signed [15:0] prev_data;
  logic signed [15:0] exp_q [$];

  always #5 clk = ~clk;

  sa_output_collector #(.SIZE(SIZE), .K(K), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .srt_sig(srt_sig),
    .in1(in1), .in2(in2), .in3(in3),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  task automatic check_output(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: compares every accepted beat against the scoreboard queue.
  always @(negedge clk) begin
    logic signed [15:0] exp_v;
    if (!rst) begin
      if (prev_stall) begin
        check_output("hold_valid", int'(out_valid), 1);
        check_output("hold_data", int'(out_data), int'(prev_data));
      end
      if (out_valid && out_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_beat actual=%0d required=no_beat", out_data);
        end else begin
          exp_v = exp_q.pop_front();
          check_output("beat", int'(out_data), int'(exp_v));
        end
      end
      if (done) begin
        done_cnt++;
        check_output("done_on_last", int'(out_valid && out_ready && exp_q.size() == 0), 1);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // kind 0: ramp 100*r+c, kind 1: +20000, kind 2: -20000
  function automatic logic signed [15:0] lane_val(input int kind, input int k);
    case (kind)
      0:       return 16'(100 * (k / SIZE) + (k % SIZE));
      1:       return 16'sd20000;
      default: return -16'sd20000;
    endcase
  endfunction

  function automatic logic signed [15:0] exp_val(input int kind, input int idx);
    int r, c;
    r = idx / OUT;
    c = idx % OUT + (K - 1);
    case (kind)
      0:       return 16'(3 * (100 * r + c));
      1:       return SAT_MAX;
      default: return SAT_MIN;
    endcase
  endfunction

  task automatic apply_stimulus(input int kind, input int abort_at, input int rst_at,
                                input bit keep_high);
    bit stopped = 1'b0;
    if (abort_at < 0 && rst_at < 0)
      for (int i = 0; i < NO; i++) exp_q.push_back(exp_val(kind, i));
    for (int j = 0; j < NS + 2 && !stopped; j++) begin
      @(posedge clk);
      #1;
      if (j == 5) check_output("busy_capture", int'(busy), 1);
      if (j == abort_at) begin
        srt_sig = 1'b0;
        in1 = '0; in2 = '0; in3 = '0;
        stopped = 1'b1;
      end else if (j == rst_at) begin
        rst = 1'b1;
        srt_sig = 1'b0;
        in1 = '0; in2 = '0; in3 = '0;
        #1;
        check_output("rst_capture_valid", int'(out_valid), 0);
        check_output("rst_capture_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stopped = 1'b1;
      end else begin
        srt_sig = 1'b1;
        in1 = (j < NS) ? lane_val(kind, j) : 16'sd0;
        in2 = (j >= 1 && j - 1 < NS) ? lane_val(kind, j - 1) : 16'sd0;
        in3 = (j >= 2 && j - 2 < NS) ? lane_val(kind, j - 2) : 16'sd0;
      end
    end
    if (!stopped) begin
      @(posedge clk);
      #1;
      in1 = '0; in2 = '0; in3 = '0;
      if (!keep_high) srt_sig = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int start_done = done_cnt;
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt > start_done) seen = 1'b1;
    end
    check_output({name, "_done_seen"}, int'(seen), 1);
    check_output({name, "_busy_after"}, int'(busy), 0);
    check_output({name, "_valid_after"}, int'(out_valid), 0);
    check_output({name, "_all_beats"}, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check_output({name, "_done_once"}, done_cnt - start_done, 1);
  endtask

  initial begin
    int base;
    bit reached;
    rst = 1'b1;
    srt_sig = 1'b0;
    in1 = '0; in2 = '0; in3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_valid", int'(out_valid), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_done", int'(done), 0);
    check_output("reset_data", int'(out_data), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] ramp frame");
    apply_stimulus(0, -1, -1, 1'b0);
    wait_done("ramp");

    $display("[TB] saturation frames");
    apply_stimulus(1, -1, -1, 1'b0);
    wait_done("sat_pos");
    apply_stimulus(2, -1, -1, 1'b0);
    wait_done("sat_neg");

    $display("[TB] backpressure frame");
    bp_en = 1'b1;
    apply_stimulus(0, -1, -1, 1'b0);
    wait_done("backpressure");
    bp_en = 1'b0;

    $display("[TB] held start");
    base = beat_cnt;
    apply_stimulus(0, -1, -1, 1'b1);
    wait_done("held");
    repeat (30) @(posedge clk);
    #1;
    check_output("held_beats", beat_cnt - base, NO);
    check_output("held_no_restart", int'(busy), 0);
    srt_sig = 1'b0;
    apply_stimulus(0, -1, -1, 1'b0);
    wait_done("held_second");

    $display("[TB] reset during capture");
    apply_stimulus(0, -1, 10, 1'b0);
    repeat (3) @(posedge clk);
    apply_stimulus(0, -1, -1, 1'b0);
    wait_done("after_rst_capture");

    $display("[TB] reset during drain");
    base = beat_cnt;
    reached = 1'b0;
    apply_stimulus(0, -1, -1, 1'b0);
    for (int i = 0; i < 500 && !reached; i++) begin
      @(posedge clk);
      #1;
      if (beat_cnt - base >= 7) reached = 1'b1;
    end
    check_output("drain_beat7_reached", int'(reached), 1);
    check_output("drain_valid_before_rst", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    check_output("rst_drain_valid", int'(out_valid), 0);
    check_output("rst_drain_busy", int'(busy), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    apply_stimulus(0, -1, -1, 1'b0);
    wait_done("after_rst_drain");

    $display("[TB] abort");
    base = beat_cnt;
    apply_stimulus(0, 20, -1, 1'b0);
    repeat (60) @(posedge clk);
    #1;
    check_output("abort_no_beats", beat_cnt - base, 0);
    check_output("abort_busy", int'(busy), 0);
    check_output("abort_done_count", int'(done), 0);
    apply_stimulus(0, -1, -1, 1'b0);
    wait_done("after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_output_collector.md
Name: sa_output_collector

Overview:
- Receiving end of the systolic-array (SA) data path.
- The SA returns three lane streams with the same staircase skew the input feeder applies: lane 2 runs 1 cycle behind lane 1, lane 3 runs 2 cycles behind.
- The block de-skews the lanes and sums each aligned triple with saturation. It discards the K-1 warm-up columns of each row window and buffers the OUT x OUT result map.
- It then drains the map row-major over a valid/ready stream to the next layer.

Parameters:
- SIZE, 7, input image dimension; samples per row window per lane.
- K, 3, kernel dimension; number of lanes and warm-up columns discarded (K-1).
- DATA_W, 16, signed lane and output width.
- OUT is a localparam equal to SIZE-K+1 (5 at defaults); it is not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- srt_sig  in  1  SA start; first cycle high marks lane-1 sample 0.
- in1  in  DATA_W  signed lane-1 partial sum.
- in2  in  DATA_W  signed lane-2 partial sum (+1 cycle skew).
- in3  in  DATA_W  signed lane-3 partial sum (+2 cycle skew).
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  signed result, row-major.
- busy  out  1  high in CAPTURE or DRAIN.
- done  out  1  one-cycle pulse on the cycle the last beat is accepted.

Behaviour:
- Reset (async, any state): state=IDLE; all counters 0; delay lines 0; out_valid=0, out_data=0, busy=0, done=0. Buffer contents are don't-care.
- Timing: let t0 be the first cycle with srt_sig=1 while in IDLE (rising-edge detect).
  - Lane 1 sample k is at t0+k, lane 2 at t0+1+k, lane 3 at t0+2+k.
  - in1 is delayed 2 cycles and in2 1 cycle, so that triple k is aligned at t0+2+k.
- Sum: 18-bit signed sum of the three lanes, saturated to DATA_W (clamp to +32767 / -32768). It is registered; the buffer write for sample k occurs at t0+3+k.
- Counters: col 0..SIZE-1 (wraps, then row increments) and row 0..OUT-1. A sample is stored at buf[row][col-(K-1)] only when col >= K-1. Each frame has OUT*SIZE samples (35 at defaults); 25 are stored.
- States:
  - IDLE: srt_sig rising edge -> CAPTURE.
  - CAPTURE: consume one aligned sample per cycle.
    - After the last sample is written -> DRAIN.
    - If srt_sig falls before the last lane-1 sample has entered -> abort: counters clear, go to IDLE, no output is produced.
  - DRAIN: out_valid=1 starting the cycle after the final buffer write. Read index runs 0..OUT*OUT-1.
    - out_data and out_valid hold stable while out_valid && !out_ready.
    - Index advances on out_valid && out_ready.
    - When the last beat is accepted: done=1 for that cycle, then out_valid=0 -> REARM.
  - REARM: wait for srt_sig=0, then -> IDLE.
- srt_sig and lane data are ignored during DRAIN and REARM. srt_sig held high past the frame (the feeder keeps it high and sends zeros) never starts a second frame.
- busy=1 exactly in CAPTURE and DRAIN.

Decomposition:
- Shared package sa_pkg holds:
  - DATA_W.
  - Saturation limits SAT_MAX / SAT_MIN.
  - The collector state encoding IDLE / CAPTURE / DRAIN / REARM.
- One sub-module, sa_deskew: a per-lane parameterised delay line (lane i delayed K-1-i cycles) that also produces the aligned valid. The feeder team reuses the same sub-module for its skew.

Test Plan:
- Ramp: each lane carries value 100*r+c with the proper skew, SIZE=7.
  - -> 25 beats in order: first 6 (r0,c2), fifth 18, last 1218 (3*406).
  - done pulses once; busy=0 afterwards.
- Saturation: all lanes +20000 -> every beat 32767. All lanes -20000 -> every beat -32768.
- Backpressure: out_ready random 50%.
  - -> all 25 values appear exactly once, in order.
  - out_data is stable whenever valid && !ready.
- Held start: srt_sig stays high 30 cycles beyond the frame -> exactly 25 beats, no second frame.
  - srt_sig low for 1 cycle, then high with a new frame -> a second correct 25-beat frame.
- Reset mid-operation: assert rst during CAPTURE at sample 10, and separately at DRAIN beat 7.
  - -> out_valid=0 and busy=0 immediately (asynchronous).
  - The next full frame is output correctly.
- Abort: srt_sig drops at lane-1 sample 20 -> no out_valid and no done; the block returns to IDLE and accepts the next frame.
